prefetch_unit: RTL and testbench
================================

# prefetch_unit

Parametrised instruction-fetch front end for the ARMv4 core. It replaces the combinational PC-to-instruction path with a request/acknowledge instruction-memory interface that tolerates wait states, and a DEPTH-entry prefetch queue. Queued instructions are handed to decode with their addresses. Branch, PC-write and reset redirects flush the queue and discard any stale in-flight response.

## Interface
Parameters:
- bus, 32: data/address width.
- DEPTH, 4: queue entries; power of two, ≥ 2.
- RESET_PC, 32'd0: first fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  bus  word-aligned fetch address; stable while imem_req=1.
- imem_ack  in  1  memory accepts and returns data this cycle; ignored unless imem_req=1.
- imem_rdata  in  bus  instruction word, valid with imem_ack.
- instr_valid  out  1  queue head valid.
- instr  out  bus  head instruction; 0 when instr_valid=0.
- instr_pc  out  bus  head instruction address; 0 when instr_valid=0.
- instr_ready  in  1  consumer takes head when instr_valid=1.
- redirect  in  1  flush and restart fetch.
- redirect_pc  in  bus  new fetch address; bits [1:0] forced to 00.

## Operation
- Registers:
  - fetch_pc: next address to fetch.
  - FIFO storage of {pc, instr}.
  - rd_ptr/wr_ptr: log2(DEPTH) bits, wrap modulo DEPTH.
  - count: $clog2(DEPTH+1) bits.
  - state.
- State FETCH:
  - imem_req = (count < DEPTH); imem_addr = fetch_pc.
  - On ack: push {fetch_pc, imem_rdata}; fetch_pc += 4; stay in FETCH. Zero-wait memory therefore sustains 1 instr/cycle.
  - On req without ack: go to WAIT.
- State WAIT: imem_req=1, imem_addr held. On ack: push, fetch_pc += 4, go to FETCH.
- State DISCARD: imem_req=1, imem_addr = stale address, held. On ack: drop data, go to FETCH.
- imem_req and imem_addr never depend combinationally on instr_ready or redirect.
- Pop: instr_valid & instr_ready. Push and pop in the same cycle leaves count unchanged; pointers both advance.
- Redirect has priority over push and pop in its cycle:
  - count ← 0, pointers ← 0, fetch_pc ← {redirect_pc[bus-1:2], 2'b00}.
  - Any concurrent pop is void.
  - If imem_req=1 without ack: next state is DISCARD.
  - If imem_req=1 with ack: data is dropped; next state is FETCH.
  - Otherwise: next state is FETCH.
  - Redirect while in DISCARD: update fetch_pc and stay in DISCARD.
- Space check uses count only; no pop lookahead.

## Timing
- Reset values: state FETCH, fetch_pc=RESET_PC, count=0, imem_req=0 while reset=1, instr_valid=0, instr=0, instr_pc=0.
- First cycle after reset release: imem_req=1, imem_addr=RESET_PC.
- Latency from imem_ack to instr_valid: 1 cycle when the queue was empty. There is no bypass.
- Latency from redirect to the first request at the new PC:
  - Next cycle if no request was outstanding or ack coincided.
  - Otherwise the cycle after the stale ack.
- Full queue (count=DEPTH): imem_req=0 from the cycle count reaches DEPTH. A pop restores the request the following cycle.
- Reset asserted mid-request: the outstanding request is abandoned. The memory model must tolerate loss of the request.

## Structure
- Package prefetch_pkg holds:
  - typedef enum logic [1:0] {FETCH, WAIT, DISCARD} fetch_state_t.
  - localparam PC_STEP = 4.
- Sub-module prefetch_fifo (synchronous FIFO, parametrised width = 2·bus, DEPTH; push, pop, flush, count, head).
- The FSM and fetch_pc live in prefetch_unit.

## Test plan
1. Zero-wait memory (ack tied to req), ready=1 → imem_addr 0,4,8,… in consecutive cycles; instr_valid from cycle 2; instr_pc 0,4,8,… one per cycle.
2. DEPTH=4, ready=0 → exactly 4 acks, then imem_req=0; raise ready → instr_pc 0,4,8,C popped in order; req resumes at 0x10 the cycle after the first pop.
3. Ack delayed 3 cycles at addr 0x8 → imem_req=1 and imem_addr=0x8 for 3 cycles; single push; next addr 0xC.
4. Redirect to 0x100 during WAIT at 0x8, ack 2 cycles later with 0xDEADBEEF → instr_valid=0 next cycle; DISCARD; 0xDEADBEEF never appears; next request addr 0x100.
5. Redirect redirect_pc=0x203 in the same cycle as ack and pop → pushed data dropped, count=0, pop ignored; next imem_addr=0x200.
6. Reset asserted with count=3 in WAIT → next cycle instr_valid=0, imem_req=0; after release first imem_addr=RESET_PC.

Source files
------------

// File: rtl/prefetch_pkg.sv
// Shared types and constants for the instruction prefetch front end.
package prefetch_pkg;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    localparam int PC_STEP = 4;

endpackage

// File: rtl/prefetch_fifo.sv
// Synchronous FIFO holding {pc, instr} pairs; flush empties it in one cycle.
module prefetch_fifo
    import prefetch_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [WIDTH-1:0]             push_data,
    output logic [WIDTH-1:0]             head,
    output logic                         head_valid,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    rd_ptr_r;
    logic [PW-1:0]    wr_ptr_r;
    logic [CW-1:0]    count_r;
    logic             push_s;
    logic             pop_s;

    // Qualify requests: flush wins, never overfill or underflow.
    always_comb begin
        push_s = push && !flush && (count_r != FULL);
        pop_s  = pop && !flush && (count_r != {CW{1'b0}});
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents are only observed through the valid-gated head.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Head presentation, forced to zero when empty.
    always_comb begin
        head_valid = (count_r != {CW{1'b0}});
        count      = count_r;
        if (head_valid) begin
            head = mem_r[rd_ptr_r];
        end else begin
            head = {WIDTH{1'b0}};
        end
    end

endmodule

// File: rtl/prefetch_unit.sv
// Instruction fetch front end: req/ack memory port, prefetch queue and
// redirect handling that discards any stale in-flight response.
module prefetch_unit
    import prefetch_pkg::*;
#(
    parameter int             bus      = 32,
    parameter int             DEPTH    = 4,
    parameter logic [bus-1:0] RESET_PC = 32'd0
) (
    input  logic           clk,
    input  logic           reset,
    output logic           imem_req,
    output logic [bus-1:0] imem_addr,
    input  logic           imem_ack,
    input  logic [bus-1:0] imem_rdata,
    output logic           instr_valid,
    output logic [bus-1:0] instr,
    output logic [bus-1:0] instr_pc,
    input  logic           instr_ready,
    input  logic           redirect,
    input  logic [bus-1:0] redirect_pc
);

    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    fetch_state_t     state_r;
    fetch_state_t     next_state_s;
    logic [bus-1:0]   fetch_pc_r;
    logic [bus-1:0]   stale_addr_r;
    logic [CW-1:0]    count_s;
    logic [2*bus-1:0] head_s;
    logic             head_valid_s;
    logic             req_s;
    logic [bus-1:0]   addr_s;
    logic             ack_s;
    logic             push_s;
    logic             pop_s;

    // Request/address depend only on state, count and registered addresses.
    always_comb begin
        if (reset) begin
            req_s = 1'b0;
        end else if (state_r == FETCH) begin
            req_s = (count_s < FULL);
        end else begin
            req_s = 1'b1;
        end
        if (state_r == DISCARD) begin
            addr_s = stale_addr_r;
        end else begin
            addr_s = fetch_pc_r;
        end
        ack_s  = req_s && imem_ack;
        push_s = ack_s && (state_r != DISCARD) && !redirect;
        pop_s  = head_valid_s && instr_ready && !redirect;
    end

    // Next-state selection; a redirect with an unanswered request must eat the stale ack.
    always_comb begin
        next_state_s = state_r;
        if (redirect) begin
            if (req_s && !ack_s) begin
                next_state_s = DISCARD;
            end else begin
                next_state_s = FETCH;
            end
        end else begin
            case (state_r)
                FETCH: begin
                    if (req_s && !ack_s) begin
                        next_state_s = WAIT;
                    end else begin
                        next_state_s = FETCH;
                    end
                end
                WAIT: begin
                    if (ack_s) begin
                        next_state_s = FETCH;
                    end else begin
                        next_state_s = WAIT;
                    end
                end
                DISCARD: begin
                    if (ack_s) begin
                        next_state_s = FETCH;
                    end else begin
                        next_state_s = DISCARD;
                    end
                end
                default: next_state_s = FETCH;
            endcase
        end
    end

    // FSM, fetch address and the address still owed an ack after a redirect.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= FETCH;
            fetch_pc_r   <= RESET_PC;
            stale_addr_r <= RESET_PC;
        end else begin
            state_r <= next_state_s;
            if (redirect) begin
                fetch_pc_r <= {redirect_pc[bus-1:2], 2'b00};
            end else if (push_s) begin
                fetch_pc_r <= fetch_pc_r + bus'(PC_STEP);
            end else begin
                fetch_pc_r <= fetch_pc_r;
            end
            if (state_r != DISCARD) begin
                stale_addr_r <= addr_s;
            end else begin
                stale_addr_r <= stale_addr_r;
            end
        end
    end

    prefetch_fifo #(
        .WIDTH (2*bus),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push_s),
        .pop        (pop_s),
        .flush      (redirect),
        .push_data  ({fetch_pc_r, imem_rdata}),
        .head       (head_s),
        .head_valid (head_valid_s),
        .count      (count_s)
    );

    // Port drive.
    always_comb begin
        imem_req    = req_s;
        imem_addr   = addr_s;
        instr_valid = head_valid_s;
        instr       = head_s[bus-1:0];
        instr_pc    = head_s[2*bus-1:bus];
    end

endmodule

// File: tb/tb_prefetch_unit.sv
// Directed bench for prefetch_unit: expected {pc, instr} pairs are queued by
// the stimulus and checked by an independent monitor on every consumed entry.
module tb_prefetch_unit;

    logic        clk         = 1'b0;
    logic        reset       = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;
    logic        redirect    = 1'b0;
    logic [31:0] redirect_pc = 32'd0;

    logic        ack_auto    = 1'b0;
    logic        ack_manual  = 1'b0;
    logic        rd_ovr      = 1'b0;
    logic [31:0] rd_ovr_val  = 32'd0;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];
    logic [63:0] mon_e;

    prefetch_unit #(
        .bus      (32),
        .DEPTH    (4),
        .RESET_PC (32'd0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    always #5 clk = ~clk;

    // Memory model: either zero-wait (ack follows req) or manually acked.
    assign imem_ack   = ack_auto ? imem_req : ack_manual;
    assign imem_rdata = rd_ovr ? rd_ovr_val : (imem_addr ^ 32'hA5A5_0000);

    function automatic logic [63:0] ent(input logic [31:0] pc);
        return {pc, pc ^ 32'hA5A5_0000};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        reset       = 1'b1;
        ack_auto    = 1'b0;
        ack_manual  = 1'b0;
        instr_ready = 1'b0;
        redirect    = 1'b0;
        rd_ovr      = 1'b0;
        tick;
        tick;
        reset = 1'b0;
    endtask

    // Monitor: every accepted head must match the oldest expected entry.
    always @(negedge clk) begin
        if (!reset && instr_valid && instr_ready && !redirect) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pop actual_pc=%h actual_instr=%h required=none", instr_pc, instr);
            end else begin
                mon_e = exp_q.pop_front();
                check("pop_pc", instr_pc, mon_e[63:32]);
                check("pop_instr", instr, mon_e[31:0]);
            end
        end
    end

    initial begin
        // Reset state
        tick;
        tick;
        #1;
        check_bit("rst_req", imem_req, 1'b0);
        check_bit("rst_valid", instr_valid, 1'b0);
        check("rst_instr", instr, 32'd0);
        check("rst_pc", instr_pc, 32'd0);
        reset = 1'b0;

        // Zero-wait streaming
        ack_auto    = 1'b1;
        instr_ready = 1'b1;
        for (int k = 0; k < 6; k++) exp_q.push_back(ent(32'(4 * k)));
        for (int k = 0; k < 6; k++) begin
            #1;
            check_bit("t1_req", imem_req, 1'b1);
            check("t1_addr", imem_addr, 32'(4 * k));
            check_bit("t1_valid", instr_valid, (k >= 1));
            tick;
        end
        ack_auto = 1'b0;
        tick;

        // Fill to DEPTH with ready low, then drain
        do_reset;
        ack_auto = 1'b1;
        for (int k = 0; k < 4; k++) exp_q.push_back(ent(32'(4 * k)));
        for (int k = 0; k < 4; k++) begin
            #1;
            check_bit("t2_req", imem_req, 1'b1);
            check("t2_addr", imem_addr, 32'(4 * k));
            tick;
        end
        for (int k = 0; k < 2; k++) begin
            #1;
            check_bit("t2_full_req", imem_req, 1'b0);
            check_bit("t2_full_valid", instr_valid, 1'b1);
            check("t2_head_pc", instr_pc, 32'h0);
            tick;
        end
        ack_auto    = 1'b0;
        instr_ready = 1'b1;
        tick;
        #1;
        check_bit("t2_resume_req", imem_req, 1'b1);
        check("t2_resume_addr", imem_addr, 32'h10);
        tick;
        tick;
        tick;
        #1;
        check_bit("t2_empty", instr_valid, 1'b0);

        // Three-cycle wait state at 0x8
        do_reset;
        ack_auto    = 1'b1;
        instr_ready = 1'b1;
        exp_q.push_back(ent(32'h0));
        exp_q.push_back(ent(32'h4));
        exp_q.push_back(ent(32'h8));
        tick;
        tick;
        ack_auto = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k == 2) ack_manual = 1'b1;
            #1;
            check_bit("t3_wait_req", imem_req, 1'b1);
            check("t3_wait_addr", imem_addr, 32'h8);
            tick;
        end
        ack_manual = 1'b0;
        #1;
        check("t3_next_addr", imem_addr, 32'hC);
        tick;

        // Redirect during WAIT: stale 0xDEADBEEF must be discarded
        do_reset;
        ack_auto = 1'b1;
        tick;
        tick;
        ack_auto = 1'b0;
        #1;
        check("t4_wait_addr", imem_addr, 32'h8);
        tick;
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        #1;
        check_bit("t4_pre_valid", instr_valid, 1'b1);
        tick;
        redirect = 1'b0;
        #1;
        check_bit("t4_flush_valid", instr_valid, 1'b0);
        check_bit("t4_disc_req", imem_req, 1'b1);
        check("t4_disc_addr", imem_addr, 32'h8);
        tick;
        ack_manual = 1'b1;
        rd_ovr     = 1'b1;
        rd_ovr_val = 32'hDEAD_BEEF;
        #1;
        check("t4_stale_addr", imem_addr, 32'h8);
        tick;
        rd_ovr = 1'b0;
        exp_q.push_back(ent(32'h100));
        #1;
        check_bit("t4_drop_valid", instr_valid, 1'b0);
        check_bit("t4_new_req", imem_req, 1'b1);
        check("t4_new_addr", imem_addr, 32'h100);
        tick;
        ack_manual  = 1'b0;
        instr_ready = 1'b1;
        #1;
        check_bit("t4_new_valid", instr_valid, 1'b1);
        tick;

        // Redirect coinciding with ack and pop
        do_reset;
        ack_auto = 1'b1;
        tick;
        tick;
        tick;
        instr_ready = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h203;
        #1;
        check_bit("t5_pre_valid", instr_valid, 1'b1);
        check("t5_pre_pc", instr_pc, 32'h0);
        tick;
        redirect    = 1'b0;
        instr_ready = 1'b0;
        ack_auto    = 1'b0;
        #1;
        check_bit("t5_valid", instr_valid, 1'b0);
        check_bit("t5_req", imem_req, 1'b1);
        check("t5_addr", imem_addr, 32'h200);
        tick;

        // Reset while WAITing with three queued entries
        do_reset;
        ack_auto = 1'b1;
        tick;
        tick;
        tick;
        ack_auto = 1'b0;
        #1;
        check("t6_addr", imem_addr, 32'hC);
        tick;
        #1;
        check_bit("t6_wait_req", imem_req, 1'b1);
        check_bit("t6_wait_valid", instr_valid, 1'b1);
        reset = 1'b1;
        #1;
        check_bit("t6_rst_req_now", imem_req, 1'b0);
        tick;
        #1;
        check_bit("t6_rst_valid", instr_valid, 1'b0);
        check_bit("t6_rst_req", imem_req, 1'b0);
        check("t6_rst_instr", instr, 32'd0);
        check("t6_rst_pc", instr_pc, 32'd0);
        reset = 1'b0;
        #1;
        check_bit("t6_rel_req", imem_req, 1'b1);
        check("t6_rel_addr", imem_addr, 32'd0);
        tick;

        check("sb_final", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
